fpga_pio_responder: RTL

//  Fabric-side Avalon-MM responder on the HPS lightweight bridge. HPS is the initiator.

---
 rtl/fpga_pio_responder_if.sv | 20 ++
 rtl/fpga_pio_responder.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/fpga_pio_responder_if.sv
// Avalon-MM bus bundle between the HPS lightweight bridge (master) and the
// fabric PIO responder (slave). Fixed read latency of one cycle, no waitrequest.
interface fpga_pio_responder_if;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, avs_readdatavalid
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, avs_readdatavalid
  );
endinterface

// File: rtl/fpga_pio_responder.sv
// HPS-facing PIO responder: LED/HEX0 registers, synchronised DIP switches, button edge capture and IRQ.
// Define FPGA_PIO_DEBOUNCE_EN to insert per-button debounce counters of DEBOUNCE_CYCLES.
module fpga_pio_responder #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int LED_W           = 10,
  parameter int BTN_W           = 4,
  parameter int SW_W            = 10
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  fpga_pio_responder_if.slave   avs,
  output logic                  irq,
  input  logic [BTN_W-1:0]      button_in,
  input  logic [SW_W-1:0]       dipsw_in,
  output logic [LED_W-1:0]      led_out,
  output logic [6:0]            hex0_out
);

  logic [BTN_W-1:0] btnSync1_q, btnSync2_q;
  logic [SW_W-1:0]  swSync1_q, swSync2_q;
  logic [BTN_W-1:0] btnStable, btnStableNext, btnPressed, pressEvent;

  logic [LED_W-1:0] led_q, led_d;
  logic [6:0]       hex_q, hex_d;
  logic [BTN_W-1:0] edgeFlags_q, edgeFlags_d;
  logic [BTN_W-1:0] mask_q, mask_d;
  logic [BTN_W-1:0] edgeClear;
  logic             irq_q, irq_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic             wrEn, rdEn;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      btnSync1_q <= '1;
      btnSync2_q <= '1;
      swSync1_q  <= '0;
      swSync2_q  <= '0;
    end else begin
      btnSync1_q <= button_in;
      btnSync2_q <= btnSync1_q;
      swSync1_q  <= dipsw_in;
      swSync2_q  <= swSync1_q;
    end
  end

`ifdef FPGA_PIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic [CNT_W-1:0] dbCnt_q [BTN_W];
  logic [CNT_W-1:0] dbCnt_d [BTN_W];
  logic [BTN_W-1:0] dbStable_q, dbStable_d;

  // A level is accepted only after it differs from the stable value for DEBOUNCE_CYCLES edges.
  always_comb begin
    dbStable_d = dbStable_q;
    for (int i = 0; i < BTN_W; i++) begin
      dbCnt_d[i] = '0;
      if (btnSync2_q[i] != dbStable_q[i]) begin
        if (dbCnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          dbStable_d[i] = btnSync2_q[i];
        end else begin
          dbCnt_d[i] = dbCnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      dbStable_q <= '1;
      for (int i = 0; i < BTN_W; i++) begin
        dbCnt_q[i] <= '0;
      end
    end else begin
      dbStable_q <= dbStable_d;
      for (int i = 0; i < BTN_W; i++) begin
        dbCnt_q[i] <= dbCnt_d[i];
      end
    end
  end

  assign btnStable     = dbStable_q;
  assign btnStableNext = dbStable_d;
`else
  assign btnStable     = btnSync2_q;
  assign btnStableNext = btnSync1_q;
`endif

  // Press is flagged on the same edge the stable level falls.
  assign pressEvent = btnStable & ~btnStableNext;
  assign btnPressed = ~btnStable;

  assign wrEn = avs.avs_write;
  assign rdEn = avs.avs_read & ~avs.avs_write;

  always_comb begin
    led_d     = led_q;
    hex_d     = hex_q;
    mask_d    = mask_q;
    edgeClear = '0;
    if (wrEn) begin
      case (avs.avs_address)
        3'd0:    led_d     = avs.avs_writedata[LED_W-1:0];
        3'd1:    hex_d     = avs.avs_writedata[6:0];
        3'd4:    edgeClear = avs.avs_writedata[BTN_W-1:0];
        3'd5:    mask_d    = avs.avs_writedata[BTN_W-1:0];
        default: ;
      endcase
    end
    edgeFlags_d = (edgeFlags_q & ~edgeClear) | pressEvent;
    irq_d       = |(edgeFlags_q & mask_q);

    rvalid_d = rdEn;
    rdata_d  = '0;
    if (rdEn) begin
      case (avs.avs_address)
        3'd0:    rdata_d = 32'(led_q);
        3'd1:    rdata_d = 32'(hex_q);
        3'd2:    rdata_d = 32'(btnPressed);
        3'd3:    rdata_d = 32'(swSync2_q);
        3'd4:    rdata_d = 32'(edgeFlags_q);
        3'd5:    rdata_d = 32'(mask_q);
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      led_q       <= '0;
      hex_q       <= 7'h7F;
      edgeFlags_q <= '0;
      mask_q      <= '0;
      irq_q       <= 1'b0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
    end else begin
      led_q       <= led_d;
      hex_q       <= hex_d;
      edgeFlags_q <= edgeFlags_d;
      mask_q      <= mask_d;
      irq_q       <= irq_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
    end
  end

  assign led_out               = led_q;
  assign hex0_out              = hex_q;
  assign irq                   = irq_q;
  assign avs.avs_readdata      = rdata_q;
  assign avs.avs_readdatavalid = rvalid_q;

endmodule
